// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 3;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Circular fetch queue holding {pc, instr} entries; flush overrides push and pop.
module if_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output fetch_entry_t     head_o
);

    localparam int unsigned      PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push_i && !flush_i && (count_q != DEPTH_C);
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding memory request at a time,
// queues returned words and hands them to decode; redirects flush all stale work.
module if_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    output logic        o_imemReq,
    output logic [31:0] o_imemAddr,
    input  logic        i_imemGnt,
    input  logic        i_imemRvalid,
    input  logic [31:0] i_imemRdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirectPc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_ready
);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);
    localparam logic [31:0]      RST_PC_W = {RESET_PC[31:2], 2'b00};

    state_e           state_q;
    state_e           state_d;
    logic [31:0]      fetch_pc_q;
    logic [31:0]      fetch_pc_d;
    logic [31:0]      req_pc_q;
    logic [31:0]      req_pc_d;
    logic             discard_q;
    logic             discard_d;
    logic             req_q;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_post;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;
    logic             push_c;
    logic             pop_c;
    logic             room_idle_c;
    logic             room_post_c;
    logic             unused_redirect_lsb;

    assign unused_redirect_lsb = ^i_redirectPc[1:0];

    // Room is judged with the incoming word counted but before any pop this cycle.
    always_comb begin
        push_c           = (state_q == S_WAIT) && i_imemRvalid && !discard_q && !i_redirect;
        pop_c            = (count != '0) && i_ready;
        count_post       = count + CNT_W'(push_c);
        room_idle_c      = count < DEPTH_C;
        room_post_c      = count_post < DEPTH_C;
        push_entry.pc    = req_pc_q;
        push_entry.instr = i_imemRdata;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_redirect || room_idle_c) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (i_imemGnt) begin
                    state_d    = S_WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    discard_d  = i_redirect;
                end
            end
            S_WAIT: begin
                if (i_imemRvalid) begin
                    discard_d = 1'b0;
                    state_d   = (i_redirect || room_post_c) ? S_REQ : S_IDLE;
                end else if (i_redirect) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A redirect target overrides any sequential PC update.
        if (i_redirect) begin
            fetch_pc_d = {i_redirectPc[31:2], 2'b00};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RST_PC_W;
            req_pc_q   <= RST_PC_W;
            discard_q  <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
            req_q      <= (state_d == S_REQ);
        end
    end

    if_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk_i       (i_clk),
        .rst_ni      (i_reset_n),
        .push_i      (push_c),
        .push_data_i (push_entry),
        .pop_i       (pop_c),
        .flush_i     (i_redirect),
        .count_o     (count),
        .head_o      (head)
    );

    assign o_imemReq  = req_q;
    assign o_imemAddr = fetch_pc_q;
    assign o_valid    = (count != '0);
    assign o_instr    = o_valid ? head.instr : NOP;
    assign o_pc       = o_valid ? head.pc : 32'h0;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a memory responder plus a scoreboard of expected {pc, instr} words.
module tb_if_fetch;
    import if_pkg::*;

    logic        i_clk;
    logic        i_reset_n;
    logic        o_imemReq;
    logic [31:0] o_imemAddr;
    logic        i_imemGnt;
    logic        i_imemRvalid;
    logic [31:0] i_imemRdata;
    logic        i_redirect;
    logic [31:0] i_redirectPc;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        i_ready;

    int n_vec;
    int n_err;

    // Knobs written only by the main sequence
    int gnt_delay;
    int rv_delay;
    int stray_cnt;

    // Memory/scoreboard state written only by the model process
    fetch_entry_t exp_q[$];
    bit           inflight;
    bit           stale;
    logic [31:0]  infl_addr;
    int           rv_left;
    int           gnt_cnt;
    int           stray_seen;
    logic         p_req;
    logic         p_valid;
    logic [31:0]  p_addr;
    logic [31:0]  p_instr;
    logic [31:0]  p_pc;

    if_fetch #(
        .RESET_PC  (32'h0000_0100),
        .BUF_DEPTH (2)
    ) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .o_imemReq    (o_imemReq),
        .o_imemAddr   (o_imemAddr),
        .i_imemGnt    (i_imemGnt),
        .i_imemRvalid (i_imemRvalid),
        .i_imemRdata  (i_imemRdata),
        .i_redirect   (i_redirect),
        .i_redirectPc (i_redirectPc),
        .o_valid      (o_valid),
        .o_instr      (o_instr),
        .o_pc         (o_pc),
        .i_ready      (i_ready)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0050_0093 : {a[19:0], 12'h093};
    endfunction

    task automatic step();
        @(negedge i_clk);
        #1;
    endtask

    // Memory responder and scoreboard: commit the previous edge, sample, then drive.
    initial begin : mem_model
        fetch_entry_t e;
        i_imemGnt    = 1'b0;
        i_imemRvalid = 1'b0;
        i_imemRdata  = 32'h0;
        inflight     = 1'b0;
        stale        = 1'b0;
        infl_addr    = 32'h0;
        rv_left      = 0;
        gnt_cnt      = 0;
        stray_seen   = 0;
        p_req        = 1'b0;
        p_valid      = 1'b0;
        p_addr       = 32'h0;
        p_instr      = 32'h0;
        p_pc         = 32'h0;
        forever begin
            @(negedge i_clk);
            if (!i_reset_n) begin
                exp_q.delete();
                inflight = 1'b0;
                stale    = 1'b0;
                gnt_cnt  = 0;
            end else begin
                if (p_valid && i_ready && !i_redirect) begin
                    if (exp_q.size() == 0) begin
                        check("sb_extra", 32'(p_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_pc", p_pc, e.pc);
                        check("sb_instr", p_instr, e.instr);
                    end
                end
                if (i_imemRvalid && inflight) begin
                    if (!stale && !i_redirect) begin
                        e.pc    = infl_addr;
                        e.instr = i_imemRdata;
                        exp_q.push_back(e);
                    end
                    inflight = 1'b0;
                    stale    = 1'b0;
                end else if (inflight && i_redirect) begin
                    stale = 1'b1;
                end
                if (p_req && i_imemGnt) begin
                    inflight  = 1'b1;
                    infl_addr = p_addr;
                    stale     = i_redirect;
                    rv_left   = rv_delay;
                end
                if (i_redirect) begin
                    exp_q.delete();
                end
            end

            p_req   = o_imemReq;
            p_valid = o_valid;
            p_addr  = o_imemAddr;
            p_instr = o_instr;
            p_pc    = o_pc;

            i_imemGnt    = 1'b0;
            i_imemRvalid = 1'b0;
            if (stray_seen != stray_cnt) begin
                stray_seen   = stray_cnt;
                i_imemRvalid = 1'b1;
                i_imemRdata  = 32'hDEAD_BEEF;
            end else if (inflight) begin
                if (rv_left <= 1) begin
                    i_imemRvalid = 1'b1;
                    i_imemRdata  = instr_of(infl_addr);
                end else begin
                    rv_left--;
                end
            end
            if (o_imemReq && !inflight && i_reset_n) begin
                if (gnt_cnt >= gnt_delay) begin
                    i_imemGnt = 1'b1;
                    gnt_cnt   = 0;
                end else begin
                    gnt_cnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main_seq
        n_vec        = 0;
        n_err        = 0;
        i_reset_n    = 1'b0;
        i_ready      = 1'b0;
        i_redirect   = 1'b0;
        i_redirectPc = 32'h0;
        gnt_delay    = 0;
        rv_delay     = 1;
        stray_cnt    = 0;

        // Reset values and first fetch
        repeat (3) step();
        check("rst_req", 32'(o_imemReq), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_addr", o_imemAddr, 32'h100);
        check("rst_instr", o_instr, NOP);
        check("rst_pc", o_pc, 32'h0);
        i_reset_n = 1'b1;
        step();
        check("first_req", 32'(o_imemReq), 32'd1);
        check("first_addr", o_imemAddr, 32'h100);
        for (int i = 0; i < 10 && !o_valid; i++) step();
        check("first_valid", 32'(o_valid), 32'd1);
        check("first_instr", o_instr, 32'h0050_0093);
        check("first_pc", o_pc, 32'h100);

        // Backpressure: queue fills, requests stop
        repeat (8) step();
        check("bp_req_idle", 32'(o_imemReq), 32'd0);
        check("bp_head_pc", o_pc, 32'h100);

        // One pop restarts fetching; grant arrives after 3 wait cycles
        gnt_delay = 3;
        i_ready   = 1'b1;
        step();
        i_ready = 1'b0;
        check("bp_next_pc", o_pc, 32'h104);
        for (int i = 0; i < 10 && !o_imemReq; i++) step();
        for (int k = 0; k < 4; k++) begin
            check("gw_req", 32'(o_imemReq), 32'd1);
            check("gw_addr", o_imemAddr, 32'h108);
            step();
        end
        check("gw_granted", 32'(o_imemReq), 32'd0);

        // Free-running drain
        gnt_delay = 0;
        i_ready   = 1'b1;
        repeat (20) step();

        // Redirect while a response is outstanding and the queue holds a word
        i_ready  = 1'b0;
        rv_delay = 4;
        for (int i = 0; i < 40 && !(inflight && o_valid && !i_imemRvalid); i++) step();
        check("rd_setup", 32'(inflight && o_valid && !i_imemRvalid), 32'd1);
        i_redirect   = 1'b1;
        i_redirectPc = 32'h203;
        step();
        i_redirect = 1'b0;
        check("rd_flush_valid", 32'(o_valid), 32'd0);
        check("rd_wait_req", 32'(o_imemReq), 32'd0);
        for (int i = 0; i < 20 && !o_imemReq; i++) step();
        check("rd_next_req", 32'(o_imemReq), 32'd1);
        check("rd_next_addr", o_imemAddr, 32'h200);
        rv_delay = 1;
        i_ready  = 1'b1;
        repeat (12) step();

        // Redirect coinciding with a returning word and a pop
        i_ready = 1'b0;
        for (int i = 0; i < 40 && !(o_valid && i_imemRvalid); i++) step();
        check("rvrd_setup", 32'(o_valid && i_imemRvalid), 32'd1);
        i_ready      = 1'b1;
        i_redirect   = 1'b1;
        i_redirectPc = 32'h3F0;
        step();
        i_redirect = 1'b0;
        i_ready    = 1'b0;
        check("rvrd_valid", 32'(o_valid), 32'd0);
        check("rvrd_instr", o_instr, NOP);
        check("rvrd_req", 32'(o_imemReq), 32'd1);
        check("rvrd_addr", o_imemAddr, 32'h3F0);
        i_ready = 1'b1;
        repeat (12) step();

        // Reset during an outstanding response, then a stray rvalid after release
        i_ready  = 1'b0;
        rv_delay = 5;
        for (int i = 0; i < 40 && !(inflight && !i_imemRvalid); i++) step();
        check("mrst_setup", 32'(inflight), 32'd1);
        i_reset_n = 1'b0;
        #1;
        check("mrst_valid", 32'(o_valid), 32'd0);
        check("mrst_req", 32'(o_imemReq), 32'd0);
        check("mrst_addr", o_imemAddr, 32'h100);
        stray_cnt++;
        step();
        i_reset_n = 1'b1;
        step();
        check("prst_valid", 32'(o_valid), 32'd0);
        check("prst_req", 32'(o_imemReq), 32'd1);
        check("prst_addr", o_imemAddr, 32'h100);
        rv_delay = 1;
        i_ready  = 1'b1;
        repeat (12) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage; sits directly upstream of the decode stage.
- Owns the program counter and issues single-outstanding word requests to instruction memory.
- Buffers returned words with their PCs in a 2-entry queue and presents them to decode over a valid/ready handshake.
- Accepts PC redirects from the execute stage (branch/jump), flushing all stale work.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0.
- BUF_DEPTH, 2, fetch-queue entries; legal values 2 and 4.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_reset_n  input  1  reset; asynchronous, active-low.
- o_imemReq  output  1  instruction-memory request valid.
- o_imemAddr  output  32  request word address.
- i_imemGnt  input  1  memory accepted the request this cycle.
- i_imemRvalid  input  1  read data valid; always arrives at least 1 cycle after the grant.
- i_imemRdata  input  32  read instruction word.
- i_redirect  input  1  take new PC (branch/jump resolved).
- i_redirectPc  input  32  redirect target.
- o_valid  output  1  fetched instruction available to decode.
- o_instr  output  32  instruction word; 32'h0000_0013 (NOP) when o_valid=0.
- o_pc  output  32  PC of o_instr; 0 when o_valid=0.
- i_ready  input  1  decode accepts o_instr this cycle.

Behaviour:
- Reset values (asynchronous, while i_reset_n=0):
  - state=S_IDLE, fetchPc=RESET_PC, queue empty, discard=0.
  - o_imemReq=0, o_imemAddr=RESET_PC, o_valid=0, o_instr=NOP, o_pc=0.
- FSM state S_IDLE:
  - o_imemReq=0.
  - Go to S_REQ when room=1, where room = (count + outstanding) < BUF_DEPTH.
- FSM state S_REQ:
  - o_imemReq=1, o_imemAddr=fetchPc.
  - Address held stable until granted; the only exception is a redirect, which may change it.
  - On i_imemGnt: fetchPc<=fetchPc+4 (32-bit wrap, no overflow flag), outstanding=1, go to S_WAIT.
- FSM state S_WAIT:
  - o_imemReq=0.
  - On i_imemRvalid: if discard=0, push {reqPc, i_imemRdata}; clear discard and outstanding.
  - Then go to S_REQ if room (evaluated post-push, pre-pop), else S_IDLE.
- i_imemRvalid outside S_WAIT is ignored.
- Latency:
  - With zero-wait grant and 1-cycle data, the word is pushed on the edge that samples rvalid.
  - o_valid is high the cycle after that edge.
  - Peak throughput is 1 instruction per 2 cycles.
- Output side:
  - o_valid = (count != 0); o_instr/o_pc = head entry.
  - Pop on o_valid && i_ready.
  - Push and pop in the same cycle are both honoured.
  - Push never occurs when full, because room is reserved at request time.
- Redirect has the highest priority and acts on the edge where it is sampled:
  - fetchPc <= {i_redirectPc[31:2], 2'b00}.
  - Queue flushed (count=0); a simultaneous pop is ignored; o_valid=0 the next cycle.
  - In S_REQ without grant: stay in S_REQ, new address next cycle.
  - In S_REQ with grant: go to S_WAIT with discard=1; fetchPc takes the redirect PC, not +4.
  - In S_WAIT without rvalid: discard=1, stay in S_WAIT.
  - In S_WAIT with rvalid: the word is dropped; go to S_REQ.
  - In S_IDLE: go to S_REQ (queue is now empty).
- Reset mid-operation: everything returns to reset values immediately. A memory response arriving after reset release is ignored (state is S_IDLE).
- Back-to-back redirects: the last one wins; discard stays set until the single in-flight response returns.

Decomposition:
- Shared package if_pkg:
  - state enum {S_IDLE, S_REQ, S_WAIT}.
  - NOP constant 32'h0000_0013.
  - Fetch-entry struct {pc[31:0], instr[31:0]}.
- Sub-module if_fifo: BUF_DEPTH-entry circular queue.
  - Ports: push, pop, flush, count, head.
  - Flush wins over push/pop.
  - Pointers wrap modulo BUF_DEPTH.
- FSM, PC and discard logic live in if_fetch.

Test Plan:
- Reset/first fetch: RESET_PC=32'h100, hold reset 3 cycles, Gnt tied 1, Rvalid 1 cycle after grant with 32'h00500093.
  - During reset: o_imemReq=0, o_valid=0.
  - After release: o_imemAddr=0x100; then o_valid=1, o_instr=0x00500093, o_pc=0x100.
- Backpressure: i_ready=0, memory always grants.
  - Two words fetched (0x100, 0x104); o_imemReq stays 0 afterwards.
  - One pop restarts the request at 0x108.
  - The queue delivers 0x100 then 0x104 in order.
- Grant wait states: Gnt delayed 3 cycles.
  - o_imemReq=1 and o_imemAddr=0x108 stable all 3 cycles; fetchPc advances only after the grant.
- Redirect during S_WAIT to 32'h203:
  - The in-flight response is dropped (never visible on o_instr).
  - Next request address is 0x200.
  - Queue flushed; o_valid=0 the following cycle even with entries present.
- Redirect coinciding with i_imemRvalid and a pop: word dropped, pop ignored, count=0, next o_imemAddr = redirect target.
- Reset asserted mid-S_WAIT, then rvalid pulses after release:
  - Pulse ignored, o_valid=0.
  - First request after release goes to RESET_PC.
